seq_detector_param: RTL and testbench

- Parametrised serial pattern detector; the next generation of the fixed 3-bit "101" Mealy detector.
- Samples one serial bit per enabled clock and flags when the most recent bits equal a programmable pattern.
- Pattern is up to MAX_LEN bits, with runtime-selectable length and overlap mode, and build-time Mealy or Moore output.
- Keeps a saturating match counter; sits directly on a serial input stream in single-clock designs.

---
 rtl/seq_detector_param.sv | 110 +++++++++++
 tb/tb_seq_detector_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Serial pattern detector: programmable pattern, length and overlap mode,
// build-time Mealy/Moore match output and a saturating match counter.
module seq_detector_param #(
  parameter int                 MAX_LEN         = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_0101),
  parameter int                 DEFAULT_LEN     = 3,
  parameter int                 MEALY           = 1,
  parameter int                 CNT_W           = 8,
  localparam int                LEN_W           = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  // The oldest history bit is shifted out before it can ever be compared,
  // so only MAX_LEN-1 past samples are kept.
  logic [MAX_LEN-2:0] hist;
  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   len;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W-1:0]   len_clamped;
  logic               overlap;
  logic               hit;

  assign cand     = {hist, din};
  assign fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
  end

  assign hit = en & ~cfg_load & (fill_inc >= {1'b0, len})
             & (((cand ^ pat) & mask) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist    <= '0;
      fill    <= '0;
      pat     <= DEFAULT_PATTERN;
      len     <= LEN_W'(DEFAULT_LEN);
      overlap <= 1'b1;
    end else if (cfg_load) begin
      hist    <= '0;
      fill    <= '0;
      pat     <= cfg_pattern;
      len     <= len_clamped;
      overlap <= cfg_overlap;
    end else if (en) begin
      hist <= cand[MAX_LEN-2:0];
      if (hit && !overlap) begin
        fill <= '0;
      end else if (fill != LEN_MAX) begin
        fill <= fill + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_count <= '0;
    end else if (clr_count) begin
      match_count <= '0;
    end else if (hit && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

  generate
    if (MEALY != 0) begin : g_mealy
      assign match = hit;
    end else begin : g_moore
      logic match_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          match_q <= 1'b0;
        end else begin
          match_q <= hit;
        end
      end
      assign match = match_q;
    end
  endgenerate

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: Mealy, Moore and 4-bit-counter builds share
// one directed stimulus; expected match values go through scoreboard queues.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic               din = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               clr_count = 1'b0;

  logic       match_a, match_b, match_c;
  logic [7:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;

  int passed = 0;
  int total  = 0;
  bit q_a[$];
  bit q_b[$];
  bit moore_s;

  always #5 clk = ~clk;

  seq_detector_param #(.MEALY(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .match(match_a), .match_count(cnt_a));

  seq_detector_param #(.MEALY(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .match(match_b), .match_count(cnt_b));

  seq_detector_param #(.MEALY(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .match(match_c), .match_count(cnt_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Mealy monitor: match is judged mid-cycle while din is presented.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (en && !cfg_load) begin
        if (q_a.size() == 0) begin
          total++;
          $display("FAIL mealy_queue: got empty expected entry");
        end else begin
          chk("mealy_match", match_a, q_a.pop_front());
          chk("mealy_match_c", match_c, dut_c_exp_last());
        end
      end else begin
        chk("mealy_idle", match_a, 0);
      end
    end
  end

  bit last_a;
  function automatic bit dut_c_exp_last();
    return last_a;
  endfunction

  // Moore monitor: match is judged just after the edge that sampled din.
  always @(posedge clk) begin
    moore_s = rst && en && !cfg_load;
    #1;
    if (moore_s) begin
      if (q_b.size() == 0) begin
        total++;
        $display("FAIL moore_queue: got empty expected entry");
      end else begin
        chk("moore_match", match_b, q_b.pop_front());
      end
    end else if (rst) begin
      chk("moore_idle", match_b, 0);
    end
  end

  task automatic send(input bit d, input bit exp, input bit clr = 1'b0);
    @(negedge clk);
    en = 1'b1; din = d; cfg_load = 1'b0; clr_count = clr;
    last_a = exp;
    q_a.push_back(exp);
    q_b.push_back(exp);
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0; din = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input bit ov);
    @(negedge clk);
    en = 1'b1; din = 1'b1; cfg_load = 1'b1; clr_count = 1'b0;
    cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
  endtask

  task automatic clear();
    @(negedge clk);
    en = 1'b0; cfg_load = 1'b0; clr_count = 1'b1;
  endtask

  task automatic chk_cnt(input string name, input int ea, input int ec);
    chk({name, "_cnt8"}, cnt_a, ea);
    chk({name, "_cnt4"}, cnt_c, ec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit s1[6] = '{0, 1, 0, 1, 0, 1};
    bit s3[7] = '{1, 1, 0, 1, 1, 0, 1};
    bit s9[8] = '{1, 0, 1, 1, 0, 1, 1, 0};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_match", match_a, 0);
    chk("reset_match_moore", match_b, 0);
    chk_cnt("reset", 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // defaults, overlapping 101
    for (int i = 0; i < 6; i++) send(s1[i], (i == 3) || (i == 5));
    idle();
    chk_cnt("default_101", 2, 2);
    clear(); idle();
    chk_cnt("clr_only", 0, 0);

    // non-overlapping 101
    load(8'b101, 4'd3, 1'b0);
    for (int i = 0; i < 6; i++) send(s1[i], i == 3);
    idle();
    chk_cnt("nonoverlap_101", 1, 1);
    clear();

    // 1101 overlapping, then non-overlapping
    load(8'b1101, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) send(s3[i], (i == 3) || (i == 6));
    idle();
    chk_cnt("overlap_1101", 2, 2);
    clear();
    load(8'b1101, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) send(s3[i], i == 3);
    idle();
    chk_cnt("nonoverlap_1101", 1, 1);
    clear();

    // en=0 gaps do not break detection
    load(8'b101, 4'd3, 1'b1);
    send(1, 0); idle(); idle();
    send(0, 0); idle();
    send(1, 1); idle();
    chk_cnt("gaps", 1, 1);
    clear();

    // saturation of the 4-bit counter, then clr on a hit edge
    send(1, 0);
    for (int i = 0; i < 16; i++) begin
      send(0, 0);
      send(1, 1);
    end
    idle();
    chk_cnt("sat16", 16, 15);
    send(0, 0); send(1, 1); idle();
    chk_cnt("sat17", 17, 15);
    send(0, 0); send(1, 1, 1'b1); idle();
    chk_cnt("clr_wins", 0, 0);

    // reset mid-stream: pre-reset bits must not complete a pattern
    send(1, 0); send(0, 0);
    @(negedge clk);
    en = 1'b0; rst = 1'b0;
    #1;
    chk("midreset_match", match_a, 0);
    chk_cnt("midreset", 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(1, 0); idle();
    chk_cnt("after_reset", 0, 0);

    // cfg_len=0 clamps to 1, pattern bit 1
    load(8'h01, 4'd0, 1'b1);
    send(1, 1); send(0, 0); send(1, 1); send(1, 1);
    idle();
    chk_cnt("len0", 3, 3);
    clear();

    // cfg_len=12 clamps to 8
    load(8'b1011_0110, 4'd12, 1'b1);
    for (int i = 0; i < 8; i++) send(s9[i], i == 7);
    idle();
    chk_cnt("len12", 1, 1);

    idle(); idle();
    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
